// File: rtl/mpt_pkg.sv
// MPT shared types: access/permission encodings plus the PLB cache entry, tag and flush types.
// Also provides the permission check used by the PLB lookup path.
package mpt_pkg;

   localparam int PAGESIZE     = 4096;
   localparam int PAGE_OFFSET  = $clog2(PAGESIZE);
   localparam int MPT_XLEN     = 64;
   localparam int MPT_SDID_LEN = 6;

   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'd0,
      ACCESS_READ  = 2'd1,
      ACCESS_WRITE = 2'd2,
      ACCESS_EXEC  = 2'd3
   } mpt_access_e;

   typedef enum logic [2:0] {
      ALLOW_NONE = 3'b000,
      ALLOW_R    = 3'b001,
      ALLOW_W    = 3'b010,
      ALLOW_RW   = 3'b011,
      ALLOW_X    = 3'b100,
      ALLOW_RX   = 3'b101,
      ALLOW_WX   = 3'b110,
      ALLOW_RWX  = 3'b111
   } mpt_permissions_e;

   typedef enum logic [1:0] {
      PLB_FLUSH_ALL       = 2'd0,
      PLB_FLUSH_SDID      = 2'd1,
      PLB_FLUSH_SDID_ADDR = 2'd2,
      PLB_FLUSH_RSVD      = 2'd3
   } plb_flush_e;

   typedef logic [MPT_XLEN-PAGE_OFFSET-1:0] plb_tag_t;

   typedef struct packed {
      logic                    valid;
      logic [MPT_SDID_LEN-1:0] sdid;
      plb_tag_t                tag;
      mpt_permissions_e        perms;
   } plb_cache_entry_t;

   function automatic logic perm_allows(input mpt_permissions_e p, input mpt_access_e a);
      case (a)
         ACCESS_READ:  return p[0];
         ACCESS_WRITE: return p[1];
         ACCESS_EXEC:  return p[2];
         default:      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// PLB replacement choice: lowest-index invalid entry, else the round-robin pointer.
// Purely combinational, no backpressure.
module mpt_plb_victim_sel
   import mpt_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] valid_i,
   input  logic [IDX_W-1:0]       ptr_i,
   output logic [IDX_W-1:0]       victim_o,
   output logic                   all_valid_o
);

   always_comb begin
      all_valid_o = &valid_i;
      victim_o    = ptr_i;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_i[i]) victim_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/mpt_plb_cache.sv
// Fully associative PLB caching MPT walk results per {sdid, page}; 1-cycle registered lookup.
// No lookup backpressure; fills are refused only while a flush is in progress.
module mpt_plb_cache
   import mpt_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int NUM_ENTRIES = 8,
   parameter int SDID_LEN    = 6,
   parameter int PAGE_OFFSET = 12,
   parameter int CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lkp_valid_i,
   input  logic [SDID_LEN-1:0] lkp_sdid_i,
   input  logic [XLEN-1:0]     lkp_spa_i,
   input  logic [1:0]          lkp_access_i,
   output logic                rsp_valid_o,
   output logic                rsp_hit_o,
   output logic [2:0]          rsp_perms_o,
   output logic                rsp_allow_o,
   input  logic                fill_valid_i,
   output logic                fill_ready_o,
   input  logic [SDID_LEN-1:0] fill_sdid_i,
   input  logic [XLEN-1:0]     fill_spa_i,
   input  logic [2:0]          fill_perms_i,
   input  logic                flush_i,
   input  logic [1:0]          flush_type_i,
   input  logic [SDID_LEN-1:0] flush_sdid_i,
   input  logic [XLEN-1:0]     flush_spa_i,
   output logic [CNT_W-1:0]    hit_cnt_o,
   output logic [CNT_W-1:0]    miss_cnt_o
);

   localparam int TAG_W = XLEN - PAGE_OFFSET;
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   typedef struct packed {
      logic [SDID_LEN-1:0] sdid;
      logic [TAG_W-1:0]    tag;
      mpt_permissions_e    perms;
   } entry_t;

   entry_t                 ent_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [NUM_ENTRIES-1:0] lkp_match, fill_match, flush_clr;
   logic [IDX_W-1:0]       ptr_q, ptr_d, victim_idx, fill_idx;
   logic                   all_valid, fill_acc, fill_hit, fill_same, hit_d;
   mpt_permissions_e       perms_sel;
   logic                   rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_allow_q, rsp_allow_d;
   mpt_permissions_e       rsp_perms_q, rsp_perms_d;
   logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [TAG_W-1:0]       lkp_tag, fill_tag, flush_tag;
   logic                   unused_lsbs;

   assign lkp_tag     = lkp_spa_i[XLEN-1:PAGE_OFFSET];
   assign fill_tag    = fill_spa_i[XLEN-1:PAGE_OFFSET];
   assign flush_tag   = flush_spa_i[XLEN-1:PAGE_OFFSET];
   assign unused_lsbs = ^{lkp_spa_i[PAGE_OFFSET-1:0], fill_spa_i[PAGE_OFFSET-1:0],
                          flush_spa_i[PAGE_OFFSET-1:0]};
   assign fill_ready_o = !flush_i;

   mpt_plb_victim_sel #(.NUM_ENTRIES(NUM_ENTRIES)) u_victim_sel (
      .valid_i     (valid_q),
      .ptr_i       (ptr_q),
      .victim_o    (victim_idx),
      .all_valid_o (all_valid)
   );

   always_comb begin
      fill_acc   = fill_valid_i && !flush_i;
      lkp_match  = '0;
      fill_match = '0;
      flush_clr  = '0;
      perms_sel  = ALLOW_NONE;
      fill_idx   = victim_idx;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         lkp_match[i]  = valid_q[i] && ent_q[i].sdid == lkp_sdid_i && ent_q[i].tag == lkp_tag;
         fill_match[i] = valid_q[i] && ent_q[i].sdid == fill_sdid_i && ent_q[i].tag == fill_tag;
         if (flush_i) begin
            case (plb_flush_e'(flush_type_i))
               PLB_FLUSH_ALL:       flush_clr[i] = 1'b1;
               PLB_FLUSH_SDID:      flush_clr[i] = ent_q[i].sdid == flush_sdid_i;
               PLB_FLUSH_SDID_ADDR: flush_clr[i] = ent_q[i].sdid == flush_sdid_i &&
                                                   ent_q[i].tag == flush_tag;
               default:             flush_clr[i] = 1'b0;
            endcase
         end
      end
      // Descending scan so the lowest index wins on both paths.
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (lkp_match[i] && !flush_clr[i]) perms_sel = ent_q[i].perms;
         if (fill_match[i]) fill_idx = IDX_W'(i);
      end
      fill_hit  = |fill_match;
      // A same-cycle fill of the looked-up key makes the old contents stale.
      fill_same = fill_acc && fill_sdid_i == lkp_sdid_i && fill_tag == lkp_tag;
      hit_d     = (|(lkp_match & ~flush_clr)) && !fill_same;

      valid_d = valid_q & ~flush_clr;
      ptr_d   = ptr_q;
      if (fill_acc) begin
         valid_d[fill_idx] = 1'b1;
         if (!fill_hit && all_valid) ptr_d = ptr_q + IDX_W'(1);
      end

      rsp_valid_d = lkp_valid_i;
      rsp_hit_d   = lkp_valid_i && hit_d;
      rsp_perms_d = rsp_hit_d ? perms_sel : ALLOW_NONE;
      rsp_allow_d = rsp_hit_d && perm_allows(perms_sel, mpt_access_e'(lkp_access_i));

      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (lkp_valid_i && hit_d && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (lkp_valid_i && !hit_d && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_perms_q <= ALLOW_NONE;
         rsp_allow_q <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         valid_q     <= valid_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_perms_q <= rsp_perms_d;
         rsp_allow_q <= rsp_allow_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_acc) begin
         ent_q[fill_idx] <= '{sdid: fill_sdid_i, tag: fill_tag, perms: mpt_permissions_e'(fill_perms_i)};
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = rsp_hit_q;
   assign rsp_perms_o = rsp_perms_q;
   assign rsp_allow_o = rsp_allow_q;
   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_mpt_plb_cache.sv
// Directed bench for mpt_plb_cache: vector table plus hand sequences for same-cycle and reset cases.
// Counters are narrowed to 4 bits so saturation is reachable quickly.
module tb_mpt_plb_cache;
   import mpt_pkg::*;

   localparam int XLEN = 64;
   localparam int NE   = 8;
   localparam int SL   = 6;
   localparam int PO   = 12;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   localparam logic [1:0] K_L = 2'd0, K_F = 2'd1, K_X = 2'd2;
   localparam logic [1:0] A_N = 2'd0, A_R = 2'd1, A_W = 2'd2, A_X = 2'd3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            lkp_valid = 1'b0;
   logic [SL-1:0]   lkp_sdid = '0;
   logic [XLEN-1:0] lkp_spa = '0;
   logic [1:0]      lkp_access = '0;
   logic            rsp_valid, rsp_hit, rsp_allow, fill_ready;
   logic [2:0]      rsp_perms;
   logic            fill_valid = 1'b0;
   logic [SL-1:0]   fill_sdid = '0;
   logic [XLEN-1:0] fill_spa = '0;
   logic [2:0]      fill_perms = '0;
   logic            flush = 1'b0;
   logic [1:0]      flush_type = '0;
   logic [SL-1:0]   flush_sdid = '0;
   logic [XLEN-1:0] flush_spa = '0;
   logic [CW-1:0]   hit_cnt, miss_cnt;

   int tests = 0;
   int fails = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   always #5 clk = ~clk;

   mpt_plb_cache #(.XLEN(XLEN), .NUM_ENTRIES(NE), .SDID_LEN(SL), .PAGE_OFFSET(PO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .lkp_valid_i(lkp_valid), .lkp_sdid_i(lkp_sdid), .lkp_spa_i(lkp_spa), .lkp_access_i(lkp_access),
      .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_perms_o(rsp_perms), .rsp_allow_o(rsp_allow),
      .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_sdid_i(fill_sdid),
      .fill_spa_i(fill_spa), .fill_perms_i(fill_perms),
      .flush_i(flush), .flush_type_i(flush_type), .flush_sdid_i(flush_sdid), .flush_spa_i(flush_spa),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [5:0]  sdid;
      logic [63:0] spa;
      logic [2:0]  arg;
      logic        eh;
      logic [2:0]  ep;
      logic        ea;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] k, input logic [5:0] sd, input logic [63:0] a,
                               input logic [2:0] arg, input logic eh, input logic [2:0] ep,
                               input logic ea);
      vec_t v;
      v.kind = k; v.sdid = sd; v.spa = a; v.arg = arg; v.eh = eh; v.ep = ep; v.ea = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_rsp(input string nm, input logic eh, input logic [2:0] ep, input logic ea);
      chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(1));
      chk({nm, " rsp_hit"}, 64'(rsp_hit), 64'(eh));
      chk({nm, " rsp_perms"}, 64'(rsp_perms), 64'(ep));
      chk({nm, " rsp_allow"}, 64'(rsp_allow), 64'(ea));
      if (eh) begin
         if (exp_hits < CMAX) exp_hits++;
      end else begin
         if (exp_miss < CMAX) exp_miss++;
      end
      chk({nm, " hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
      chk({nm, " miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_lookup(input string nm, input logic [5:0] sd, input logic [63:0] a,
                            input logic [1:0] acc, input logic eh, input logic [2:0] ep,
                            input logic ea);
      lkp_valid = 1'b1; lkp_sdid = sd; lkp_spa = a; lkp_access = acc;
      step();
      lkp_valid = 1'b0;
      check_rsp(nm, eh, ep, ea);
   endtask

   task automatic do_fill(input string nm, input logic [5:0] sd, input logic [63:0] a,
                          input logic [2:0] p);
      fill_valid = 1'b1; fill_sdid = sd; fill_spa = a; fill_perms = p;
      #1;
      chk({nm, " fill_ready"}, 64'(fill_ready), 64'(1));
      step();
      fill_valid = 1'b0;
   endtask

   task automatic do_flush(input logic [1:0] t, input logic [5:0] sd, input logic [63:0] a);
      flush = 1'b1; flush_type = t; flush_sdid = sd; flush_spa = a;
      step();
      flush = 1'b0;
   endtask

   initial begin
      // Build the vector table.
      vecs.push_back(mk(K_L, 3, 64'h8000_1234, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_F, 3, 64'h8000_1000, 3'd3, 0, 0, 0));
      vecs.push_back(mk(K_L, 3, 64'h8000_1FF8, A_W, 1, 3'd3, 1));
      vecs.push_back(mk(K_L, 3, 64'h8000_1FF8, A_X, 1, 3'd3, 0));
      vecs.push_back(mk(K_L, 4, 64'h8000_1FF8, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 3, 64'h8000_1FF8, A_N, 1, 3'd3, 0));
      vecs.push_back(mk(K_L, 3, 64'h8000_1000, A_R, 1, 3'd3, 1));
      for (int k = 1; k <= 7; k++) vecs.push_back(mk(K_F, 5, 64'(k) << 12, 3'd1, 0, 0, 0));
      vecs.push_back(mk(K_F, 5, 64'h8000, 3'd1, 0, 0, 0));           // evicts entry 0
      vecs.push_back(mk(K_L, 3, 64'h8000_1000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 5, 64'h1000, A_R, 1, 3'd1, 1));
      vecs.push_back(mk(K_L, 5, 64'h8000, A_R, 1, 3'd1, 1));
      vecs.push_back(mk(K_F, 5, 64'h9000, 3'd7, 0, 0, 0));           // evicts entry 1
      vecs.push_back(mk(K_L, 5, 64'h1000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 5, 64'h9000, A_X, 1, 3'd7, 1));
      vecs.push_back(mk(K_L, 5, 64'h2000, A_W, 1, 3'd1, 0));
      vecs.push_back(mk(K_F, 5, 64'h2000, 3'd5, 0, 0, 0));           // in-place refill
      for (int k = 3; k <= 8; k++) vecs.push_back(mk(K_L, 5, 64'(k) << 12, A_R, 1, 3'd1, 1));
      vecs.push_back(mk(K_L, 5, 64'h9000, A_R, 1, 3'd7, 1));
      vecs.push_back(mk(K_L, 5, 64'h2000, A_X, 1, 3'd5, 1));
      vecs.push_back(mk(K_L, 5, 64'h2000, A_W, 1, 3'd5, 0));
      vecs.push_back(mk(K_F, 5, 64'hA000, 3'd1, 0, 0, 0));           // pointer still 2
      vecs.push_back(mk(K_L, 5, 64'h2000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 5, 64'h3000, A_R, 1, 3'd1, 1));
      vecs.push_back(mk(K_L, 5, 64'hA000, A_R, 1, 3'd1, 1));
      vecs.push_back(mk(K_X, 0, 64'h0, 3'd0, 0, 0, 0));
      vecs.push_back(mk(K_L, 5, 64'h3000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 5, 64'hA000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_F, 1, 64'h1000, 3'd1, 0, 0, 0));
      vecs.push_back(mk(K_F, 1, 64'h2000, 3'd1, 0, 0, 0));
      vecs.push_back(mk(K_F, 2, 64'hA000, 3'd3, 0, 0, 0));
      vecs.push_back(mk(K_F, 2, 64'hB000, 3'd3, 0, 0, 0));
      vecs.push_back(mk(K_X, 1, 64'h0, 3'd1, 0, 0, 0));
      vecs.push_back(mk(K_L, 1, 64'h1000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 1, 64'h2000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 2, 64'hA000, A_R, 1, 3'd3, 1));
      vecs.push_back(mk(K_L, 2, 64'hB000, A_W, 1, 3'd3, 1));
      vecs.push_back(mk(K_X, 2, 64'hA123, 3'd2, 0, 0, 0));
      vecs.push_back(mk(K_L, 2, 64'hA000, A_R, 0, 3'd0, 0));
      vecs.push_back(mk(K_L, 2, 64'hB000, A_R, 1, 3'd3, 1));
      vecs.push_back(mk(K_X, 2, 64'hB000, 3'd3, 0, 0, 0));           // reserved type
      vecs.push_back(mk(K_L, 2, 64'hB000, A_R, 1, 3'd3, 1));
      vecs.push_back(mk(K_X, 1, 64'hB000, 3'd2, 0, 0, 0));           // sdid mismatch
      vecs.push_back(mk(K_L, 2, 64'hB000, A_R, 1, 3'd3, 1));
      vecs.push_back(mk(K_X, 0, 64'h0, 3'd0, 0, 0, 0));
      vecs.push_back(mk(K_L, 2, 64'hB000, A_R, 0, 3'd0, 0));

      repeat (2) step();
      rst = 1'b0;
      chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset rsp_hit", 64'(rsp_hit), 64'(0));
      chk("reset rsp_perms", 64'(rsp_perms), 64'(0));
      chk("reset rsp_allow", 64'(rsp_allow), 64'(0));
      chk("reset hit_cnt", 64'(hit_cnt), 64'(0));
      chk("reset miss_cnt", 64'(miss_cnt), 64'(0));

      foreach (vecs[i]) begin
         case (vecs[i].kind)
            K_L: do_lookup($sformatf("vec%0d", i), vecs[i].sdid, vecs[i].spa, vecs[i].arg[1:0],
                           vecs[i].eh, vecs[i].ep, vecs[i].ea);
            K_F: do_fill($sformatf("vec%0d", i), vecs[i].sdid, vecs[i].spa, vecs[i].arg);
            default: do_flush(vecs[i].arg[1:0], vecs[i].sdid, vecs[i].spa);
         endcase
      end

      step();
      chk("idle rsp_valid", 64'(rsp_valid), 64'(0));
      chk("idle rsp_hit", 64'(rsp_hit), 64'(0));

      // Flush and fill in the same cycle: fill refused.
      flush = 1'b1; flush_type = 2'd1; flush_sdid = 6'd7;
      fill_valid = 1'b1; fill_sdid = 6'd2; fill_spa = 64'hC000; fill_perms = 3'd7;
      #1;
      chk("flush+fill ready", 64'(fill_ready), 64'(0));
      step();
      flush = 1'b0; fill_valid = 1'b0;
      do_lookup("flush+fill lkp", 2, 64'hC000, A_R, 0, 3'd0, 0);

      // Flush ALL with a lookup of a resident page in the same cycle.
      do_fill("res fill", 2, 64'hC000, 3'd7);
      flush = 1'b1; flush_type = 2'd0;
      lkp_valid = 1'b1; lkp_sdid = 6'd2; lkp_spa = 64'hC010; lkp_access = A_R;
      step();
      flush = 1'b0; lkp_valid = 1'b0;
      check_rsp("flushall+lkp", 0, 3'd0, 0);
      do_lookup("after flushall", 2, 64'hC000, A_R, 0, 3'd0, 0);

      // Address flush of another page does not hide a concurrent hit.
      do_fill("res fill2", 2, 64'hC000, 3'd1);
      flush = 1'b1; flush_type = 2'd2; flush_sdid = 6'd2; flush_spa = 64'hD000;
      lkp_valid = 1'b1; lkp_sdid = 6'd2; lkp_spa = 64'hC000; lkp_access = A_R;
      step();
      flush = 1'b0; lkp_valid = 1'b0;
      check_rsp("flushaddr other+lkp", 1, 3'd1, 1);

      // Fill and lookup of the same key: miss now, hit next.
      fill_valid = 1'b1; fill_sdid = 6'd2; fill_spa = 64'hD000; fill_perms = 3'd3;
      lkp_valid = 1'b1; lkp_sdid = 6'd2; lkp_spa = 64'hD008; lkp_access = A_W;
      step();
      fill_valid = 1'b0; lkp_valid = 1'b0;
      check_rsp("fill+lkp same", 0, 3'd0, 0);
      do_lookup("fill+lkp after", 2, 64'hD000, A_W, 1, 3'd3, 1);

      // Saturation of the hit counter.
      for (int k = 0; k < 18; k++) do_lookup("sat", 2, 64'hD000, A_R, 1, 3'd3, 1);
      chk("hit_cnt saturated", 64'(hit_cnt), 64'(CMAX));

      // Reset asserted during a lookup.
      lkp_valid = 1'b1; lkp_sdid = 6'd2; lkp_spa = 64'hD000; lkp_access = A_R;
      rst = 1'b1;
      step();
      rst = 1'b0; lkp_valid = 1'b0;
      exp_hits = 0; exp_miss = 0;
      chk("rst-lkp rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst-lkp rsp_hit", 64'(rsp_hit), 64'(0));
      chk("rst-lkp rsp_perms", 64'(rsp_perms), 64'(0));
      chk("rst-lkp rsp_allow", 64'(rsp_allow), 64'(0));
      chk("rst-lkp hit_cnt", 64'(hit_cnt), 64'(0));
      chk("rst-lkp miss_cnt", 64'(miss_cnt), 64'(0));
      do_lookup("post-reset lkp", 2, 64'hD000, A_R, 0, 3'd0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
